// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised inter-stage register chain (IF/ID .. MEM/WB) with
// per-stage stall/flush/valid tracking, bubble insertion below a stall and a global lock.
// Latency 1 cycle per stage; a stall at stage m holds registers 0..m, iLock freezes all.
// Ports: iCLK, iRST (async active-low), iData/iValid (into reg 0), iStall/iFlush (per reg),
//        iLock, oData (reg k at [k*DATA_W +: DATA_W]), oValid, oHold, oReady.
// Optional macro PIPE_PERF_CNT_EN adds iPerfClr, oPerfStall, oPerfBubble (32-bit saturating).
module pipe_stage_chain #(
  parameter int DATA_W          = 64,
  parameter int STAGES          = 4,
  parameter int CLEAR_ON_BUBBLE = 1
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [DATA_W-1:0]        iData,
  input  logic                     iValid,
  input  logic [STAGES-1:0]        iStall,
  input  logic [STAGES-1:0]        iFlush,
  input  logic                     iLock,
`ifdef PIPE_PERF_CNT_EN
  input  logic                     iPerfClr,
  output logic [STAGES*32-1:0]     oPerfStall,
  output logic [STAGES*32-1:0]     oPerfBubble,
`endif
  output logic [STAGES*DATA_W-1:0] oData,
  output logic [STAGES-1:0]        oValid,
  output logic [STAGES-1:0]        oHold,
  output logic                     oReady
);

  logic [DATA_W-1:0] dataQ [STAGES];
  logic [STAGES-1:0] validQ;

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] upHold;   // hold of the register feeding register k
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] load;
  logic [DATA_W-1:0] upData [STAGES];
  logic [STAGES-1:0] upValid;

  // A stall anywhere at or above k holds register k: no room downstream.
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold[k] = |(iStall >> k);
    end
  end

  always_comb begin
    upData[0]  = iData;
    upValid[0] = iValid;
    upHold[0]  = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      upData[k]  = dataQ[k-1];
      upValid[k] = validQ[k-1];
      upHold[k]  = hold[k-1];
    end
  end

  // Lock beats hold, hold beats flush: a held register is never flushed.
  always_comb begin
    bubble = '0;
    load   = '0;
    for (int k = 0; k < STAGES; k++) begin
      bubble[k] = ~iLock & ~hold[k] & (iFlush[k] | upHold[k]);
      load[k]   = ~iLock & ~hold[k] & ~(iFlush[k] | upHold[k]);
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      validQ <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dataQ[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (bubble[k]) begin
          validQ[k] <= 1'b0;
          if (CLEAR_ON_BUBBLE != 0) begin
            dataQ[k] <= '0;
          end
        end else if (load[k]) begin
          // iValid=0 at reg 0 is a plain load, so its payload is kept.
          validQ[k] <= upValid[k];
          dataQ[k]  <= upData[k];
        end
      end
    end
  end

  always_comb begin
    oData = '0;
    for (int k = 0; k < STAGES; k++) begin
      oData[k*DATA_W +: DATA_W] = dataQ[k];
    end
  end

  assign oValid = validQ;
  assign oHold  = hold;
  assign oReady = ~hold[0] & ~iLock;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stallCnt  [STAGES];
  logic [31:0] bubbleCnt [STAGES];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int k = 0; k < STAGES; k++) begin
        stallCnt[k]  <= '0;
        bubbleCnt[k] <= '0;
      end
    end else if (iPerfClr) begin
      for (int k = 0; k < STAGES; k++) begin
        stallCnt[k]  <= '0;
        bubbleCnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (!iLock && hold[k] && (stallCnt[k] != 32'hFFFF_FFFF)) begin
          stallCnt[k] <= stallCnt[k] + 32'd1;
        end
        if (bubble[k] && (bubbleCnt[k] != 32'hFFFF_FFFF)) begin
          bubbleCnt[k] <= bubbleCnt[k] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    oPerfStall  = '0;
    oPerfBubble = '0;
    for (int k = 0; k < STAGES; k++) begin
      oPerfStall[k*32 +: 32]  = stallCnt[k];
      oPerfBubble[k*32 +: 32] = bubbleCnt[k];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=4, DATA_W=64): one instance with
// CLEAR_ON_BUBBLE=1 and one with CLEAR_ON_BUBBLE=0 driven by the same inputs.
module tb_pipe_stage_chain;
  localparam int DW = 64;
  localparam int NS = 4;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic [DW-1:0] iData;
  logic          iValid;
  logic [NS-1:0] iStall;
  logic [NS-1:0] iFlush;
  logic          iLock;

  logic [NS*DW-1:0] oData,  nData;
  logic [NS-1:0]    oValid, nValid;
  logic [NS-1:0]    oHold,  nHold;
  logic             oReady, nReady;

`ifdef PIPE_PERF_CNT_EN
  logic             iPerfClr;
  logic [NS*32-1:0] oPerfStall, oPerfBubble, nPerfStall, nPerfBubble;
`endif

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  pipe_stage_chain #(.DATA_W(DW), .STAGES(NS), .CLEAR_ON_BUBBLE(1)) u_dut (
    .iCLK(iCLK), .iRST(iRST), .iData(iData), .iValid(iValid),
    .iStall(iStall), .iFlush(iFlush), .iLock(iLock),
`ifdef PIPE_PERF_CNT_EN
    .iPerfClr(iPerfClr), .oPerfStall(oPerfStall), .oPerfBubble(oPerfBubble),
`endif
    .oData(oData), .oValid(oValid), .oHold(oHold), .oReady(oReady)
  );

  pipe_stage_chain #(.DATA_W(DW), .STAGES(NS), .CLEAR_ON_BUBBLE(0)) u_dutNc (
    .iCLK(iCLK), .iRST(iRST), .iData(iData), .iValid(iValid),
    .iStall(iStall), .iFlush(iFlush), .iLock(iLock),
`ifdef PIPE_PERF_CNT_EN
    .iPerfClr(iPerfClr), .oPerfStall(nPerfStall), .oPerfBubble(nPerfBubble),
`endif
    .oData(nData), .oValid(nValid), .oHold(nHold), .oReady(nReady)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkRegs(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3, input logic [3:0] ev);
    check({tag, ".r0"}, oData[0*DW +: DW], e0);
    check({tag, ".r1"}, oData[1*DW +: DW], e1);
    check({tag, ".r2"}, oData[2*DW +: DW], e2);
    check({tag, ".r3"}, oData[3*DW +: DW], e3);
    check({tag, ".v"},  {60'd0, oValid}, {60'd0, ev});
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    iRST = 1'b0; iData = '0; iValid = 1'b0; iStall = '0; iFlush = '0; iLock = 1'b0;
`ifdef PIPE_PERF_CNT_EN
    iPerfClr = 1'b0;
`endif
    #2;
    checkRegs("reset", 0, 0, 0, 0, 4'b0000);
    check("reset.hold",  {60'd0, oHold}, 64'd0);
    check("reset.ready", {63'd0, oReady}, 64'd1);
    @(negedge iCLK);
    iRST = 1'b1;

    // Streaming 1..5: after edge 1 only reg 0 is live; after edge 5 regs = 5,4,3,2.
    for (int i = 1; i <= 5; i++) begin
      iData = 64'(i); iValid = 1'b1;
      tick();
      if (i == 1) checkRegs("lat1", 1, 0, 0, 0, 4'b0001);
    end
    checkRegs("stream", 5, 4, 3, 2, 4'b1111);

    // Stall at reg 1: regs 0..1 held, reg 2 bubble, reg 3 advances.
    iStall = 4'b0010; iData = 6;
    #1;
    check("stall.ready", {63'd0, oReady}, 64'd0);
    check("stall.hold",  {60'd0, oHold}, 64'h3);
    tick();
    checkRegs("stall", 5, 4, 0, 3, 4'b1011);
    // Without clearing, the bubbled register keeps its own previous payload (3).
    check("nc.r2",    nData[2*DW +: DW], 64'd3);
    check("nc.valid", {60'd0, nValid}, 64'hB);

    // Stall at 1 with flush at 0,1,3: held regs ignore flush, reg 2 bubbles, reg 3 flushed.
    iStall = 4'b0010; iFlush = 4'b1011; iData = 7;
    tick();
    checkRegs("flushhold", 5, 4, 0, 0, 4'b0011);

    // Lock for 3 edges with changing inputs: nothing moves.
    iLock = 1'b1;
    iData = 8;  iStall = 4'b0001; iFlush = 4'b1111;
    #1 check("lock.ready", {63'd0, oReady}, 64'd0);
    tick();
    iData = 9;  iStall = 4'b1000; iFlush = 4'b0101;
    tick();
    iData = 10; iStall = 4'b0000; iFlush = 4'b0000;
    tick();
    checkRegs("lock", 5, 4, 0, 0, 4'b0011);

    iLock = 1'b0; iData = 11; iValid = 1'b1;
    tick();
    checkRegs("unlock1", 11, 5, 4, 0, 4'b0111);
    iData = 12;
    tick();
    checkRegs("unlock2", 12, 11, 5, 4, 4'b1111);

    // Top-stage stall holds the whole chain.
    iStall = 4'b1000; iData = 99;
    #1 check("top.hold", {60'd0, oHold}, 64'hF);
    tick();
    checkRegs("topstall", 12, 11, 5, 4, 4'b1111);

    // iValid=0 loads payload with valid clear, payload not zeroed.
    iStall = '0; iData = 13; iValid = 1'b0;
    tick();
    checkRegs("invalid", 13, 12, 11, 5, 4'b1110);

    // Stall at 0, flush at 3: reg 1 bubble, reg 2 advances, reg 3 flushed.
    iStall = 4'b0001; iFlush = 4'b1000; iData = 14; iValid = 1'b1;
    tick();
    checkRegs("stallflush", 13, 0, 12, 0, 4'b0100);

    // Asynchronous reset between edges.
    iStall = '0; iFlush = '0;
    #3 iRST = 1'b0;
    #1 checkRegs("areset", 0, 0, 0, 0, 4'b0000);
    #1 iRST = 1'b1;
    iData = 15; iValid = 1'b1;
    tick();
    checkRegs("postrst", 15, 0, 0, 0, 4'b0001);

    // Two edges of stall at reg 2: regs 0..2 held, reg 3 bubbles.
    iStall = 4'b0100; iData = 16;
    tick();
    tick();
    checkRegs("stall2", 15, 0, 0, 0, 4'b0001);
`ifdef PIPE_PERF_CNT_EN
    for (int k = 0; k < NS; k++) begin
      check($sformatf("perfStall%0d", k), {32'd0, oPerfStall[k*32 +: 32]}, (k < 3) ? 64'd2 : 64'd0);
      check($sformatf("perfBub%0d", k), {32'd0, oPerfBubble[k*32 +: 32]}, (k == 3) ? 64'd2 : 64'd0);
    end
    iPerfClr = 1'b1;
    tick();
    iPerfClr = 1'b0;
    check("perfClr.stall",  {32'd0, oPerfStall[31:0]},  64'd0);
    check("perfClr.bubble", {32'd0, oPerfBubble[127:96]}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
